// File: rtl/pipe_stage_chain_pkg.sv
// pipe_pkg: shared constants, types and helpers for pipe_stage_chain.
//   PIPE_MAX_DEPTH - largest supported number of register slots
//   pipe_cnt_t     - 32-bit statistics counter type
//   occ_width()    - bit width needed to count 0..depth valid slots
package pipe_pkg;

  localparam int unsigned PIPE_MAX_DEPTH = 8;

  typedef logic [31:0] pipe_cnt_t;

  function automatic int unsigned occ_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_stage_chain_if.sv
// pipe_stage_chain_if: handshake bundle around a pipe_stage_chain.
//   flush                      - squash all slot contents
//   in_valid/in_data/in_ready  - upstream valid/ready handshake
//   out_valid/out_data/out_ready - downstream valid/ready handshake
//   occ, stall_cnt             - statistics (zero unless PIPE_STATS_EN)
// Modports: master = the surrounding stages / bench, slave = the chain.
interface pipe_stage_chain_if
  import pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 1
);

  localparam int unsigned OCC_W = occ_width(DEPTH);

  logic             flush;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [OCC_W-1:0] occ;
  pipe_cnt_t        stall_cnt;

  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, occ, stall_cnt
  );

  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, occ, stall_cnt
  );

endinterface

// File: rtl/pipe_stage_chain_slot.sv
// pipe_slot: one payload register with its valid bit.
//   clk, rst - clock, synchronous active-high reset (data <= RESET_VAL)
//   clr      - drop the valid bit, data holds (wins over load)
//   load     - capture d and mark valid
//   q, vld   - registered payload and valid bit
// With neither clr nor load the slot holds both fields.
module pipe_slot #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             vld
);

  logic [WIDTH-1:0] data_d, data_q;
  logic             vld_d, vld_q;

  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    if (clr) begin
      vld_d = 1'b0;
    end else if (load) begin
      vld_d  = 1'b1;
      data_d = d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= RESET_VAL;
      vld_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  end

  assign q   = data_q;
  assign vld = vld_q;

endmodule

// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: parametrised inter-stage register chain with
// valid/ready handshake and bubble collapsing.
//   CLK  - clock, all state updates on posedge
//   RST  - synchronous active-high reset, slots load RESET_VAL, invalid
//   bus  - pipe_stage_chain_if.slave: flush, in_* (upstream), out_* (downstream),
//          occ / stall_cnt statistics
// Slot 0 is the input side; slot DEPTH-1 drives out_data/out_valid directly.
// An empty slot accepts its source even while downstream is stalled.
// in_ready depends combinationally on out_ready.
// Optional feature macro: PIPE_STATS_EN enables the occ/stall_cnt counters;
// otherwise both outputs are tied to zero.
module pipe_stage_chain
  import pipe_pkg::*;
#(
  parameter int unsigned      WIDTH     = 32,
  parameter int unsigned      DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic               CLK,
  input logic               RST,
  pipe_stage_chain_if.slave bus
);

  localparam int unsigned OCC_W = occ_width(DEPTH);

  logic [DEPTH-1:0] slot_vld;
  logic [WIDTH-1:0] slot_data [DEPTH];
  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] src_vld;
  logic [WIDTH-1:0] src_data [DEPTH];
  logic [DEPTH-1:0] load;
  logic [DEPTH-1:0] clr;
  logic             all_v;

  // adv[i] = !vld[i] | adv[i+1] unrolled from the output side: a slot may
  // advance when out_ready is high or any slot from i to the output is empty.
  // Accumulating in a local keeps the chain free of self-referencing vectors.
  always_comb begin
    all_v = 1'b1;
    adv   = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      all_v              = all_v & slot_vld[DEPTH-1-k];
      adv[DEPTH-1-k]     = !all_v | bus.out_ready;
    end
  end

  always_comb begin
    src_vld     = '0;
    src_vld[0]  = bus.in_valid;
    src_data[0] = bus.in_data;
    for (int unsigned k = 1; k < DEPTH; k++) begin
      src_vld[k]  = slot_vld[k-1];
      src_data[k] = slot_data[k-1];
    end
    for (int unsigned k = 0; k < DEPTH; k++) begin
      load[k] = !bus.flush & adv[k] & src_vld[k];
      clr[k]  = bus.flush | (adv[k] & !src_vld[k]);
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    pipe_slot #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_slot (
      .clk  (CLK),
      .rst  (RST),
      .load (load[g]),
      .clr  (clr[g]),
      .d    (src_data[g]),
      .q    (slot_data[g]),
      .vld  (slot_vld[g])
    );
  end

  always_comb begin
    bus.in_ready  = adv[0] & !bus.flush;
    bus.out_valid = slot_vld[DEPTH-1];
    bus.out_data  = slot_data[DEPTH-1];
  end

`ifdef PIPE_STATS_EN
  logic [OCC_W-1:0] occ_d, occ_q;
  pipe_cnt_t        stall_cnt_d, stall_cnt_q;
  logic             in_xfer, out_xfer;

  always_comb begin
    in_xfer  = bus.in_valid & bus.in_ready;
    out_xfer = bus.out_valid & bus.out_ready;

    if (bus.flush) begin
      occ_d = '0;
    end else begin
      occ_d = occ_q + OCC_W'(in_xfer) - OCC_W'(out_xfer);
    end

    // Back-pressure cycles saturate; flush does not clear the count.
    stall_cnt_d = stall_cnt_q;
    if (bus.out_valid && !bus.out_ready && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      occ_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      occ_q       <= occ_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    bus.occ       = occ_q;
    bus.stall_cnt = stall_cnt_q;
  end
`else
  always_comb begin
    bus.occ       = '0;
    bus.stall_cnt = '0;
  end
`endif

endmodule

// File: doc/pipe_stage_chain.md
Name: pipe_stage_chain

Overview:
- Parametrised successor to the fixed inter-stage latches (IF/ID … MEM/WB).
- Generic payload bus of WIDTH bits, DEPTH register slots, per-slot valid bits.
- Valid/ready handshake with bubble collapsing: an empty slot accepts data even while downstream is stalled.
- Synchronous flush; programmable reset payload, so fields such as opcode can reset to RTYPE rather than 0.

Parameters:
- WIDTH, 32, payload width in bits (>=1).
- DEPTH, 1, number of register slots (1..8).
- RESET_VAL, '0, WIDTH-bit payload value loaded into every slot on RST.

Ports:
- CLK  in  1  clock, all state updates on posedge.
- RST  in  1  synchronous, active-high reset.
- flush  in  1  discard all slot contents (squash, e.g. branch mispredict).
- in_valid  in  1  upstream presents a payload.
- in_data  in  WIDTH  upstream payload.
- in_ready  out  1  chain accepts in_data this cycle.
- out_valid  out  1  output slot (DEPTH-1) holds a valid payload.
- out_data  out  WIDTH  payload of slot DEPTH-1.
- out_ready  in  1  downstream consumes the output this cycle.
- occ  out  $clog2(DEPTH+1)  number of valid slots (see Optional Feature).
- stall_cnt  out  32  output back-pressure cycle count (see Optional Feature).

Behaviour:
- State per slot i: data_q[i] (WIDTH bits), vld_q[i]. Slot 0 is the input side; slot DEPTH-1 drives out_data/out_valid directly (registered outputs).
- Advance terms (combinational):
  - adv[DEPTH-1] = !vld_q[DEPTH-1] | out_ready
  - adv[i] = !vld_q[i] | adv[i+1]
- in_ready = adv[0] & !flush. This is a combinational path from out_ready to in_ready, accepted by design.
- Source of slot i: in_valid/in_data for i=0, else vld_q[i-1]/data_q[i-1].
- Per cycle, in priority order:
  1. RST=1: all vld_q=0, all data_q=RESET_VAL. Holds through the cycle regardless of other inputs. Reset mid-transfer drops in-flight payloads silently.
  2. flush=1: all vld_q=0 on the next edge. data_q holds. in_data is not accepted that cycle. A payload presented with out_valid&out_ready that same cycle counts as consumed.
  3. Otherwise, for each slot with adv[i]=1: vld_q[i] <= source valid, and data_q[i] <= source data only when the source is valid; otherwise data holds. Slots with adv[i]=0 hold both fields.
- Transfers:
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
  - Both may occur in the same cycle. Full throughput is 1 payload/cycle.
- Latency: a payload accepted at edge n appears at the output after DEPTH edges if never stalled. It arrives earlier in slots only via bubble collapse; it never bypasses a slot.
- Full: all vld_q=1 and out_ready=0 -> in_ready=0, and the chain holds bit-exact.
- Empty: out_valid=0. out_data shows the last held value (or RESET_VAL) and must not be interpreted.
- Order is strictly preserved. There is no duplication and no loss except on flush or RST.
- DEPTH=1 degenerates to a single latch: in_ready = !out_valid | out_ready.

Optional Feature:
- Macro PIPE_STATS_EN.
- Defined:
  - occ is a registered count of valid slots, updated incrementally: +1 on input transfer, -1 on output transfer, net 0 when both occur. Forced to 0 on RST or flush.
  - stall_cnt increments each cycle with out_valid=1 & out_ready=0. It saturates at 32'hFFFF_FFFF, clears only on RST, and is unaffected by flush.
- Not defined: occ and stall_cnt are tied to 0 and no counter logic is synthesised. Ports remain for a stable interface.

Decomposition:
- Package pipe_pkg:
  - constant PIPE_MAX_DEPTH=8.
  - typedef pipe_cnt_t (logic [31:0]).
  - function occ_width(depth) returning $clog2(depth+1).
- Stage payload structs (e.g. the MEM/WB field bundle) are packed typedefs in cpu_types_pkg. They are cast onto in_data/out_data by the instantiating stage.
- One sub-module, pipe_slot: a single data/valid register with load/clear/hold controls. It is instantiated DEPTH times in a generate loop. Advance logic and stats live in the parent.

Test Plan:
- Reset: DEPTH=3, WIDTH=8, RESET_VAL=8'hA5, RST high 2 cycles -> out_valid=0, out_data=8'hA5, occ=0, in_ready=1.
- Streaming: out_ready=1, push 8'h01..8'h05 back-to-back -> 8'h01 at output exactly 3 edges after acceptance, then one payload/cycle in order; in_ready stays 1.
- Back-pressure: out_ready=0, push 4 payloads -> first 3 accepted, in_ready=0 on the 4th, occ=3, stall_cnt increments each stalled cycle. Release out_ready -> 4th accepted one cycle later, order preserved.
- Bubble collapse: slot pattern valid/empty/valid (slot2 valid), out_ready=0, push 8'h33 -> accepted, slots become valid/valid/valid.
- Flush with simultaneous push: chain holding 2 payloads, in_valid=1 and flush=1 -> in_ready=0, next cycle out_valid=0 and occ=0, stall_cnt unchanged.
- Reset mid-operation: full chain, out_ready=0, stall_cnt=5, RST for one cycle -> all state cleared, stall_cnt=0, out_data=RESET_VAL.
